// File: rtl/gate_seq_ctrl_pkg.sv
// ============================================================================
//  Package  : gate_seq_pkg
//  Purpose  : Shared types and defaults for the gated-pulse sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gate_seq_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      GATE  = 2'd2
   } state_t;

   // Default sizing
   localparam int DEF_N_CH = 4;
   localparam int DEF_W    = 4;

   // Per-channel configuration values after reset
   localparam int RST_DELAY = 0;
   localparam int RST_DUR   = 1;

endpackage

`default_nettype wire

// File: rtl/gate_seq_ctrl_rr_arbiter.sv
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : N-way round-robin arbiter. The search starts just after the
//             last accepted grant; the pointer moves only when a grant is
//             accepted (en high and some request present).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   input  logic                 en,
   output logic [N-1:0]         gnt_oh,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic                 gnt_valid
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] ptr;
   logic [IW-1:0] cand;
   logic [IW-1:0] pick;
   logic [N-1:0]  pick_oh;
   logic          found;

   // Find the first requester after the pointer, wrapping around
   always_comb begin
      found   = 1'b0;
      pick    = '0;
      pick_oh = '0;
      cand    = '0;
      for (int k = 0; k < N; k++) begin
         cand = IW'((int'(ptr) + 1 + k) % N);
         if (!found && req[cand]) begin
            found         = 1'b1;
            pick          = cand;
            pick_oh[cand] = 1'b1;
         end
      end
   end

   assign gnt_valid = en & found;
   assign gnt_oh    = gnt_valid ? pick_oh : '0;
   assign gnt_idx   = pick;

   // Pointer starts at the last channel so channel 0 wins first after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= IW'(N - 1);
      end else if (gnt_valid) begin
         ptr <= pick;
      end
   end

endmodule

`default_nettype wire

// File: rtl/gate_seq_ctrl.sv
// ============================================================================
//  Module   : gate_seq_ctrl
//  Purpose  : Shares one delay-then-gate pulse generator among N_CH trigger
//             channels. Trigger rising edges queue runs, which are served in
//             round-robin order with per-channel delay/duration.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_seq_ctrl
   import gate_seq_pkg::*;
#(
   parameter int N_CH = DEF_N_CH,
   parameter int W    = DEF_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_CH-1:0]         trig,
   input  logic                    cfg_we,
   input  logic [$clog2(N_CH)-1:0] cfg_ch,
   input  logic [W-1:0]            cfg_delay,
   input  logic [W-1:0]            cfg_dur,
   input  logic                    abort,
   input  logic                    ovf_clr,
   output logic                    gate,
   output logic [$clog2(N_CH)-1:0] gate_ch,
   output logic                    busy,
   output logic [N_CH-1:0]         pend,
   output logic [N_CH-1:0]         ovf
);

   localparam int CW = $clog2(N_CH);

   state_t          state;
   logic [N_CH-1:0] trig_q;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] gnt_oh;
   logic [N_CH-1:0] ovf_set;
   logic [CW-1:0]   gnt_idx;
   logic            gnt_valid;
   logic [W-1:0]    delay_r [N_CH];
   logic [W-1:0]    dur_r   [N_CH];
   logic [W-1:0]    gnt_delay;
   logic [W-1:0]    gnt_dur;
   logic [W-1:0]    cnt;
   logic [W-1:0]    dur_snap;

   assign rise      = trig & ~trig_q;
   // A rise coinciding with the grant of the same channel just re-queues it
   assign ovf_set   = rise & pend & ~gnt_oh;
   assign gnt_delay = delay_r[gnt_idx];
   assign gnt_dur   = dur_r[gnt_idx];
   assign busy      = (state != IDLE);

   rr_arbiter #(
      .N (N_CH)
   ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (pend),
      .en        (state == IDLE),
      .gnt_oh    (gnt_oh),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   // Edge detection, request queue and sticky overflow flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_q <= '0;
         pend   <= '0;
         ovf    <= '0;
      end else begin
         trig_q <= trig;
         pend   <= (pend & ~gnt_oh) | rise;
         ovf    <= (ovf & ~{N_CH{ovf_clr}}) | ovf_set;
      end
   end

   // Per-channel configuration registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            delay_r[i] <= W'(RST_DELAY);
            dur_r[i]   <= W'(RST_DUR);
         end
      end else if (cfg_we && (int'(cfg_ch) < N_CH)) begin
         delay_r[cfg_ch] <= cfg_delay;
         dur_r[cfg_ch]   <= cfg_dur;
      end
   end

   // Run sequencer: grant, count down the delay, then hold gate for dur
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gate     <= 1'b0;
         gate_ch  <= '0;
         cnt      <= '0;
         dur_snap <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_valid) begin
                  gate_ch  <= gnt_idx;
                  dur_snap <= gnt_dur;
                  if (gnt_delay != '0) begin
                     state <= DELAY;
                     cnt   <= gnt_delay;
                  end else if (gnt_dur != '0) begin
                     state <= GATE;
                     gate  <= 1'b1;
                     cnt   <= gnt_dur;
                  end
               end
            end
            DELAY: begin
               if (abort) begin
                  state <= IDLE;
               end else if (cnt == W'(1)) begin
                  if (dur_snap != '0) begin
                     state <= GATE;
                     gate  <= 1'b1;
                     cnt   <= dur_snap;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt - W'(1);
               end
            end
            GATE: begin
               if (abort || (cnt == W'(1))) begin
                  state <= IDLE;
                  gate  <= 1'b0;
               end else begin
                  cnt <= cnt - W'(1);
               end
            end
            default: begin
               state <= IDLE;
               gate  <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_gate_seq_ctrl.sv
// ============================================================================
//  Module   : tb_gate_seq_ctrl
//  Purpose  : Self-checking bench for gate_seq_ctrl. The reference model
//             describes each run as a time window [grant+delay, grant+delay+dur)
//             and keeps the request/overflow bookkeeping as plain bit vectors.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_seq_ctrl;

   localparam int N  = 4;
   localparam int W  = 4;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  trig = '0;
   logic          cfg_we = 1'b0;
   logic [CW-1:0] cfg_ch = '0;
   logic [W-1:0]  cfg_delay = '0;
   logic [W-1:0]  cfg_dur = '0;
   logic          abort = 1'b0;
   logic          ovf_clr = 1'b0;
   logic          gate;
   logic          busy;
   logic [CW-1:0] gate_ch;
   logic [N-1:0]  pend;
   logic [N-1:0]  ovf;

   gate_seq_ctrl #(.N_CH(N), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .trig      (trig),
      .cfg_we    (cfg_we),
      .cfg_ch    (cfg_ch),
      .cfg_delay (cfg_delay),
      .cfg_dur   (cfg_dur),
      .abort     (abort),
      .ovf_clr   (ovf_clr),
      .gate      (gate),
      .gate_ch   (gate_ch),
      .busy      (busy),
      .pend      (pend),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // ---------------- reference model ----------------
   int            t = 0;
   logic          m_active;
   int            m_g, m_d, m_u, m_last;
   logic [CW-1:0] m_ch;
   logic [N-1:0]  m_pend, m_ovf, m_prev;
   int            m_delay [N];
   int            m_dur   [N];

   function automatic logic m_gate();
      return m_active && (t >= m_g + m_d);
   endfunction

   task automatic model_reset();
      m_active = 1'b0;
      m_ch     = '0;
      m_last   = N - 1;
      m_pend   = '0;
      m_ovf    = '0;
      m_prev   = '0;
      m_g = 0; m_d = 0; m_u = 0;
      for (int i = 0; i < N; i++) begin
         m_delay[i] = 0;
         m_dur[i]   = 1;
      end
   endtask

   task automatic model_edge();
      logic [N-1:0] rise, clr;
      int c;
      t++;
      clr  = '0;
      rise = trig & ~m_prev;
      if (m_active) begin
         if (abort || t == m_g + m_d + m_u) m_active = 1'b0;
      end else if (m_pend != '0) begin
         c = -1;
         for (int k = 1; k <= N; k++)
            if (c < 0 && m_pend[(m_last + k) % N]) c = (m_last + k) % N;
         clr[c]   = 1'b1;
         m_last   = c;
         m_ch     = CW'(c);
         m_g      = t;
         m_d      = m_delay[c];
         m_u      = m_dur[c];
         m_active = (m_d + m_u) > 0;
      end
      m_ovf  = (ovf_clr ? '0 : m_ovf) | (rise & m_pend & ~clr);
      m_pend = (m_pend & ~clr) | rise;
      if (cfg_we) begin
         m_delay[cfg_ch] = int'(cfg_delay);
         m_dur[cfg_ch]   = int'(cfg_dur);
      end
      m_prev = trig;
   endtask

   // one clock edge; outputs are examined 1 time unit later
   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
   endtask

   task automatic cfg_write(input int ch, input int d, input int u);
      cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_delay = W'(d); cfg_dur = W'(u);
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic do_reset();
      trig = '0; cfg_we = 1'b0; abort = 1'b0; ovf_clr = 1'b0;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      #2;
      vectors++;
      if ({gate, busy, gate_ch, pend, ovf} !== '0) begin
         miscompares++;
         $display("FAIL reset: got gate=%b busy=%b ch=%0d pend=%b ovf=%b, need all zero",
                  gate, busy, gate_ch, pend, ovf);
      end
      do_reset();
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if ({gate, busy, gate_ch, pend, ovf} !== {m_gate(), m_active, m_ch, m_pend, m_ovf}) begin
            miscompares++;
            $display("FAIL reset_idle t=%0d got %b%b %0d %b %b need %b%b %0d %b %b", t, gate, busy,
                     gate_ch, pend, ovf, m_gate(), m_active, m_ch, m_pend, m_ovf);
         end
      end
   endtask

   task automatic test_basic();
      int g = -1, r = -1, f = -1;
      do_reset();
      cfg_write(1, 3, 2);
      trig = 4'b0010;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (g < 0 && busy) g = i;
         if (r < 0 && gate) r = i;
         if (r >= 0 && f < 0 && !gate) f = i;
         vectors++;
         if ({gate, busy, gate_ch, pend, ovf} !== {m_gate(), m_active, m_ch, m_pend, m_ovf}) begin
            miscompares++;
            $display("FAIL basic t=%0d got %b%b %0d %b %b need %b%b %0d %b %b", t, gate, busy,
                     gate_ch, pend, ovf, m_gate(), m_active, m_ch, m_pend, m_ovf);
         end
      end
      trig = '0;
      vectors++;
      if (g != 1 || r - g != 3 || f - r != 2 || gate_ch !== 2'd1) begin
         miscompares++;
         $display("FAIL basic_timing: grant=%0d rise=%0d fall=%0d ch=%0d, need 1 4 6 ch 1",
                  g, r, f, gate_ch);
      end
   endtask

   task automatic test_round_robin();
      logic [CW-1:0] order[$];
      logic prev_gate = 1'b0;
      do_reset();
      for (int c = 0; c < N; c++) cfg_write(c, 0, 1);
      trig = '1;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (gate && !prev_gate) order.push_back(gate_ch);
         prev_gate = gate;
         vectors++;
         if ({gate, busy, gate_ch, pend, ovf} !== {m_gate(), m_active, m_ch, m_pend, m_ovf}) begin
            miscompares++;
            $display("FAIL round_robin t=%0d got %b%b %0d %b %b need %b%b %0d %b %b", t, gate,
                     busy, gate_ch, pend, ovf, m_gate(), m_active, m_ch, m_pend, m_ovf);
         end
      end
      trig = '0;
      vectors++;
      if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 2 ||
          order[3] != 3 || ovf !== '0) begin
         miscompares++;
         $display("FAIL rr_order: got %0d pulses ovf=%b, need pulses 0,1,2,3 ovf=0",
                  order.size(), ovf);
      end
   endtask

   task automatic test_overflow();
      int  ch2_runs = 0;
      logic prev_gate = 1'b0;
      do_reset();
      cfg_write(0, 2, 3);
      cfg_write(2, 5, 5);
      trig = 4'b0101;
      for (int i = 0; i < 30; i++) begin
         if (i == 2) trig[2] = 1'b0;
         if (i == 3) trig[2] = 1'b1;
         tick();
         if (i == 3) begin
            vectors++;
            if (ovf[2] !== 1'b1) begin
               miscompares++;
               $display("FAIL ovf_set: got ovf=%b, need bit 2 set", ovf);
            end
         end
         if (gate && !prev_gate && gate_ch == 2'd2) ch2_runs++;
         prev_gate = gate;
         vectors++;
         if ({gate, busy, gate_ch, pend, ovf} !== {m_gate(), m_active, m_ch, m_pend, m_ovf}) begin
            miscompares++;
            $display("FAIL overflow t=%0d got %b%b %0d %b %b need %b%b %0d %b %b", t, gate,
                     busy, gate_ch, pend, ovf, m_gate(), m_active, m_ch, m_pend, m_ovf);
         end
      end
      vectors++;
      if (ch2_runs != 1) begin
         miscompares++;
         $display("FAIL ovf_runs: got %0d ch2 runs, need 1", ch2_runs);
      end
      trig = '0;
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      vectors++;
      if (ovf !== '0 || m_ovf !== '0) begin
         miscompares++;
         $display("FAIL ovf_clr: got ovf=%b, need 0000", ovf);
      end
   endtask

   task automatic test_boundaries();
      int hi = 0, lo = 0, z_pulse = 0;
      do_reset();
      // dur=0 on ch3: consumed without a pulse, ch0 still runs
      cfg_write(3, 0, 0);
      trig = 4'b1001;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (gate && gate_ch == 2'd3) z_pulse++;
         vectors++;
         if ({gate, busy, gate_ch, pend, ovf} !== {m_gate(), m_active, m_ch, m_pend, m_ovf}) begin
            miscompares++;
            $display("FAIL dur0 t=%0d got %b%b %0d %b %b need %b%b %0d %b %b", t, gate, busy,
                     gate_ch, pend, ovf, m_gate(), m_active, m_ch, m_pend, m_ovf);
         end
      end
      vectors++;
      if (z_pulse != 0 || pend !== '0 || gate_ch !== 2'd3) begin
         miscompares++;
         $display("FAIL dur0_result: got pulses=%0d pend=%b ch=%0d, need 0 0000 3",
                  z_pulse, pend, gate_ch);
      end
      trig = '0;
      // maximum delay and duration
      cfg_write(1, 15, 15);
      trig = 4'b0010;
      for (int i = 0; i < 36; i++) begin
         tick();
         if (gate) hi++;
         if (busy && !gate) lo++;
         vectors++;
         if ({gate, busy, gate_ch, pend, ovf} !== {m_gate(), m_active, m_ch, m_pend, m_ovf}) begin
            miscompares++;
            $display("FAIL max t=%0d got %b%b %0d %b %b need %b%b %0d %b %b", t, gate, busy,
                     gate_ch, pend, ovf, m_gate(), m_active, m_ch, m_pend, m_ovf);
         end
      end
      trig = '0;
      vectors++;
      if (hi != 15 || lo != 15) begin
         miscompares++;
         $display("FAIL max_len: got low=%0d high=%0d, need 15 15", lo, hi);
      end
      // config write landing on the grant edge uses the old values
      cfg_write(2, 1, 2);
      trig = 4'b0100;
      tick();
      cfg_we = 1'b1; cfg_ch = 2'd2; cfg_delay = 4'd3; cfg_dur = 4'd6;
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         cfg_we = 1'b0;
         if (gate) hi++;
         vectors++;
         if ({gate, busy, gate_ch, pend, ovf} !== {m_gate(), m_active, m_ch, m_pend, m_ovf}) begin
            miscompares++;
            $display("FAIL cfg_grant t=%0d got %b%b %0d %b %b need %b%b %0d %b %b", t, gate,
                     busy, gate_ch, pend, ovf, m_gate(), m_active, m_ch, m_pend, m_ovf);
         end
      end
      trig = '0;
      vectors++;
      if (hi != 2) begin
         miscompares++;
         $display("FAIL cfg_grant_len: got high=%0d, need 2 (old value)", hi);
      end
   endtask

   task automatic test_abort();
      int  wait_cnt = 0;
      logic ch1_seen = 1'b0;
      do_reset();
      cfg_write(0, 1, 10);
      cfg_write(1, 0, 2);
      trig = 4'b0011;
      // abort while idle is ignored
      abort = 1'b1;
      tick();
      abort = 1'b0;
      while (!gate && wait_cnt < 20) begin
         tick();
         wait_cnt++;
         vectors++;
         if ({gate, busy, gate_ch, pend, ovf} !== {m_gate(), m_active, m_ch, m_pend, m_ovf}) begin
            miscompares++;
            $display("FAIL abort_pre t=%0d got %b%b %0d %b %b need %b%b %0d %b %b", t, gate,
                     busy, gate_ch, pend, ovf, m_gate(), m_active, m_ch, m_pend, m_ovf);
         end
      end
      vectors++;
      if (!gate) begin
         miscompares++;
         $display("FAIL abort_wait: gate never rose within 20 cycles, need rise");
      end
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      vectors++;
      if (gate !== 1'b0 || busy !== 1'b0 || pend[1] !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_gate: got gate=%b busy=%b pend=%b, need 0 0 pend[1]=1",
                  gate, busy, pend);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         if (gate && gate_ch == 2'd1) ch1_seen = 1'b1;
         vectors++;
         if ({gate, busy, gate_ch, pend, ovf} !== {m_gate(), m_active, m_ch, m_pend, m_ovf}) begin
            miscompares++;
            $display("FAIL abort_post t=%0d got %b%b %0d %b %b need %b%b %0d %b %b", t, gate,
                     busy, gate_ch, pend, ovf, m_gate(), m_active, m_ch, m_pend, m_ovf);
         end
      end
      trig = '0;
      vectors++;
      if (!ch1_seen) begin
         miscompares++;
         $display("FAIL abort_queue: got no ch1 pulse, need one");
      end
   endtask

   task automatic test_reset_mid_run();
      int hi = 0;
      do_reset();
      cfg_write(2, 8, 3);
      trig = 4'b0100;
      tick();
      trig = 4'b0110;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if ({gate, busy, gate_ch, pend, ovf} !== {m_gate(), m_active, m_ch, m_pend, m_ovf}) begin
            miscompares++;
            $display("FAIL midrun_pre t=%0d got %b%b %0d %b %b need %b%b %0d %b %b", t, gate,
                     busy, gate_ch, pend, ovf, m_gate(), m_active, m_ch, m_pend, m_ovf);
         end
      end
      #2;
      trig = '0;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({gate, busy, gate_ch, pend, ovf} !== '0) begin
         miscompares++;
         $display("FAIL midrun_reset: got gate=%b busy=%b ch=%0d pend=%b ovf=%b, need zeros",
                  gate, busy, gate_ch, pend, ovf);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (gate) hi++;
         vectors++;
         if ({gate, busy, gate_ch, pend, ovf} !== {m_gate(), m_active, m_ch, m_pend, m_ovf}) begin
            miscompares++;
            $display("FAIL midrun_post t=%0d got %b%b %0d %b %b need %b%b %0d %b %b", t, gate,
                     busy, gate_ch, pend, ovf, m_gate(), m_active, m_ch, m_pend, m_ovf);
         end
      end
      vectors++;
      if (hi != 0) begin
         miscompares++;
         $display("FAIL midrun_nopulse: got %0d high cycles, need 0", hi);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         for (int b = 0; b < N; b++)
            if ($urandom_range(5) == 0) trig[b] = ~trig[b];
         cfg_we    = ($urandom_range(7) == 0);
         cfg_ch    = CW'($urandom_range(N - 1));
         cfg_delay = W'(($urandom_range(9) == 0) ? $urandom_range(15) : $urandom_range(3));
         cfg_dur   = W'(($urandom_range(9) == 0) ? $urandom_range(15) : $urandom_range(3));
         abort     = ($urandom_range(39) == 0);
         ovf_clr   = ($urandom_range(29) == 0);
         tick();
         vectors++;
         if ({gate, busy, gate_ch, pend, ovf} !== {m_gate(), m_active, m_ch, m_pend, m_ovf}) begin
            miscompares++;
            $display("FAIL random t=%0d got %b%b %0d %b %b need %b%b %0d %b %b", t, gate, busy,
                     gate_ch, pend, ovf, m_gate(), m_active, m_ch, m_pend, m_ovf);
         end
      end
      trig = '0; cfg_we = 1'b0; abort = 1'b0; ovf_clr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_overflow();
      test_boundaries();
      test_abort();
      test_reset_mid_run();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
